// File: rtl/yarvi_ld_align.sv
// Load-side aligner: tracks outstanding loads in order and turns each
// memory response into a sign/zero-extended register writeback.
module yarvi_ld_align #(
  parameter int DEPTH     = 4,
  parameter int LOG2DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_address,
  input  logic [4:0]  req_rd,
  input  logic        mem_valid,
  input  logic [31:0] mem_readdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_misaligned
);

  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] addr;
    logic [4:0] rd;
  } entry_t;

  localparam logic [LOG2DEPTH:0] FULL = (LOG2DEPTH+1)'(DEPTH);
  localparam logic [LOG2DEPTH-1:0] PONE = LOG2DEPTH'(1);

  entry_t                fifo_q [DEPTH];
  logic [LOG2DEPTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LOG2DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LOG2DEPTH:0]    count_q, count_d;

  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        wb_mis_q;

  logic        push, pop;
  entry_t      head;
  logic [31:0] shifted;
  logic [31:0] data_d;
  logic        mis_d;

  assign req_ready = (count_q != FULL);
  assign push      = req_valid && req_ready;
  assign pop       = mem_valid && (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];
  assign shifted   = mem_readdata >> {head.addr, 3'b000};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PONE;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    mis_d  = 1'b0;
    data_d = '0;
    unique case (head.funct3)
      3'd0: data_d = {{24{shifted[7]}}, shifted[7:0]};
      3'd4: data_d = {24'h0, shifted[7:0]};
      3'd1: begin
        mis_d  = head.addr[0];
        data_d = {{16{shifted[15]}}, shifted[15:0]};
      end
      3'd5: begin
        mis_d  = head.addr[0];
        data_d = {16'h0, shifted[15:0]};
      end
      3'd2: begin
        mis_d  = (head.addr != 2'd0);
        data_d = mem_readdata;
      end
      default: mis_d = 1'b1;
    endcase
    if (mis_d) data_d = '0;
  end

  // Entries need no reset: pointers and count define what is live.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      fifo_q[wr_ptr_q] <= '{funct3: req_funct3,
                             addr:   req_address,
                             rd:     req_rd};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_mis_q   <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wb_valid_q <= pop;
      if (pop) begin
        wb_rd_q   <= head.rd;
        wb_data_q <= data_d;
        wb_mis_q  <= mis_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(mem_valid && count_q == '0))
        else $warning("yarvi_ld_align: response with no outstanding load");
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign wb_misaligned = wb_mis_q;

endmodule

// File: tb/tb_yarvi_ld_align.sv
// Scoreboard bench for yarvi_ld_align: reference model of load
// extraction plus an in-order request queue.
module tb_yarvi_ld_align;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [1:0]  req_address;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic [31:0] mem_readdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_misaligned;

  yarvi_ld_align #(.DEPTH(4), .LOG2DEPTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_address  (req_address),
    .req_rd       (req_rd),
    .mem_valid    (mem_valid),
    .mem_readdata (mem_readdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_misaligned(wb_misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] f3;
    logic [1:0] a;
    logic [4:0] rd;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  req_t pend[$];
  exp_t expq[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic [1:0] a,
                                 input logic [4:0] rd, input logic [31:0] w);
    exp_t   r;
    int     nb;
    int     ai;
    bit     sgn;
    longint m;
    longint v;
    r.rd = rd;
    r.data = '0;
    r.mis = 1'b0;
    ai = int'(a);
    sgn = 1'b0;
    case (f3)
      3'd0: begin nb = 1; sgn = 1'b1; end
      3'd1: begin nb = 2; sgn = 1'b1; end
      3'd2: nb = 4;
      3'd4: nb = 1;
      3'd5: nb = 2;
      default: nb = 0;
    endcase
    if (nb == 0 || (ai % nb) != 0) begin
      r.mis = 1'b1;
      return r;
    end
    m = (longint'(1) << (8 * nb)) - 1;
    v = (longint'({32'h0, w}) >> (8 * ai)) & m;
    if (sgn && v > (m >> 1)) v = v - (m + 1);
    r.data = v[31:0];
    return r;
  endfunction

  // One clock of stimulus; inputs change #1 after the rising edge.
  task automatic cycle(input bit rv, input logic [2:0] f3,
                       input logic [1:0] a, input logic [4:0] rd,
                       input bit mv, input logic [31:0] d);
    bit rdy_m;
    req_t e;
    req_valid = rv;
    req_funct3 = f3;
    req_address = a;
    req_rd = rd;
    mem_valid = mv;
    mem_readdata = d;
    rdy_m = (pend.size() < 4);
    check("req_ready", {31'h0, req_ready}, {31'h0, rdy_m});
    if (mv && pend.size() != 0) begin
      e = pend.pop_front();
      expq.push_back(model(e.f3, e.a, e.rd, d));
    end
    if (rv && rdy_m) pend.push_back('{f3: f3, a: a, rd: rd});
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 3'd0, 2'd0, 5'd0, 0, 32'h0);
  endtask

  logic [4:0]  last_rd;
  logic [31:0] last_data;
  logic        last_mis;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      last_rd = '0;
      last_data = '0;
      last_mis = 1'b0;
    end else if (wb_valid) begin
      if (expq.size() == 0) begin
        check("unexpected_wb_valid", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        check("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
        check("wb_data", wb_data, e.data);
        check("wb_misaligned", {31'h0, wb_misaligned}, {31'h0, e.mis});
      end
      last_rd = wb_rd;
      last_data = wb_data;
      last_mis = wb_misaligned;
    end else begin
      check("hold_rd", {27'h0, wb_rd}, {27'h0, last_rd});
      check("hold_data", wb_data, last_data);
      check("hold_mis", {31'h0, wb_misaligned}, {31'h0, last_mis});
    end
  end

  initial begin
    reset = 1'b1;
    req_valid = 0;
    req_funct3 = '0;
    req_address = '0;
    req_rd = '0;
    mem_valid = 0;
    mem_readdata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_wb_valid", {31'h0, wb_valid}, 32'd0);
    check("rst_wb_rd", {27'h0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_mis", {31'h0, wb_misaligned}, 32'd0);
    check("rst_req_ready", {31'h0, req_ready}, 32'd1);

    // Directed alignment vectors
    cycle(1, 3'd4, 2'd3, 5'd5, 0, 32'h0);
    cycle(0, 3'd0, 2'd0, 5'd0, 1, 32'h80FF_1234);
    cycle(1, 3'd0, 2'd3, 5'd6, 0, 32'h0);
    cycle(0, 3'd0, 2'd0, 5'd0, 1, 32'h80FF_1234);
    cycle(1, 3'd1, 2'd2, 5'd7, 0, 32'h0);
    cycle(0, 3'd0, 2'd0, 5'd0, 1, 32'h8001_0000);
    cycle(1, 3'd5, 2'd0, 5'd8, 0, 32'h0);
    cycle(0, 3'd0, 2'd0, 5'd0, 1, 32'h0000_F00D);
    cycle(1, 3'd2, 2'd0, 5'd9, 0, 32'h0);
    cycle(0, 3'd0, 2'd0, 5'd0, 1, 32'hDEAD_BEEF);
    cycle(1, 3'd1, 2'd1, 5'd10, 0, 32'h0);
    cycle(0, 3'd0, 2'd0, 5'd0, 1, 32'hFFFF_FFFF);
    cycle(1, 3'd2, 2'd2, 5'd11, 0, 32'h0);
    cycle(0, 3'd0, 2'd0, 5'd0, 1, 32'hFFFF_FFFF);
    cycle(1, 3'd3, 2'd0, 5'd12, 0, 32'h0);
    cycle(0, 3'd0, 2'd0, 5'd0, 1, 32'hFFFF_FFFF);
    idle(2);

    // Fill to capacity, hold a fifth load, then drain
    for (int i = 1; i <= 4; i++) cycle(1, 3'd2, 2'd0, 5'(i), 0, 32'h0);
    cycle(1, 3'd2, 2'd0, 5'd9, 0, 32'h0);
    cycle(1, 3'd2, 2'd0, 5'd9, 0, 32'h0);
    cycle(1, 3'd2, 2'd0, 5'd9, 1, 32'h1111_0001);
    cycle(1, 3'd2, 2'd0, 5'd9, 0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(0, 3'd0, 2'd0, 5'd0, 1, 32'(i + 2));
    idle(2);

    // Back-to-back loads, responses trailing, across pointer wrap
    for (int i = 0; i < 12; i++)
      cycle(1, 3'd2, 2'd0, 5'(i + 16), i >= 2, $urandom);
    for (int i = 0; i < 6; i++) cycle(0, 3'd0, 2'd0, 5'd0, 1, $urandom);
    idle(2);

    // Response with nothing outstanding is dropped
    cycle(0, 3'd0, 2'd0, 5'd0, 1, 32'hBAD0_BAD0);
    check("orphan_wb_valid", {31'h0, wb_valid}, 32'd0);
    cycle(1, 3'd0, 2'd1, 5'd13, 0, 32'h0);
    cycle(0, 3'd0, 2'd0, 5'd0, 1, 32'h0000_8000);
    idle(2);

    // Reset with outstanding loads and a response in flight
    for (int i = 0; i < 3; i++) cycle(1, 3'd2, 2'd0, 5'(i + 24), 0, 32'h0);
    reset = 1'b1;
    mem_valid = 1'b1;
    mem_readdata = 32'hCAFE_CAFE;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    pend.delete();
    check("post_rst_wb_valid", {31'h0, wb_valid}, 32'd0);
    check("post_rst_ready", {31'h0, req_ready}, 32'd1);
    cycle(1, 3'd2, 2'd0, 5'd30, 0, 32'h0);
    cycle(0, 3'd0, 2'd0, 5'd0, 1, 32'h1234_5678);
    idle(2);

    // Randomized traffic; responses only when something is outstanding
    for (int i = 0; i < 400; i++) begin
      bit rv;
      bit mv;
      rv = ($urandom_range(0, 9) < 6);
      mv = (pend.size() != 0) && ($urandom_range(0, 9) < 5);
      cycle(rv, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), mv, $urandom);
    end
    while (pend.size() != 0) cycle(0, 3'd0, 2'd0, 5'd0, 1, $urandom);
    idle(3);
    check("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
